// File: rtl/spi_px_master.sv
// Host-side SPI mode-0 master for the pixel link: one full-duplex frame of
// PIXEL_BITS per request, MSB first, with a fixed CS-high gap between frames.
module spi_px_master #(
    parameter int PIXEL_BITS = 24,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic [PIXEL_BITS-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [PIXEL_BITS-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  spi_cs_o,
    output logic                  spi_sck_o,
    output logic                  spi_sdi_o,
    input  logic                  spi_sdo_i
);

    localparam int BW = $clog2(PIXEL_BITS + 1);
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    // The slave double-synchronises SCK, so each half-period needs >= 4 clk cycles.
    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("spi_px_master: CLK_DIV must be >= 4");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("spi_px_master: GAP_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [BW-1:0]   bit_q;
    logic [PIXEL_BITS-1:0] tx_sh_q, rx_sh_q;

    logic div_done, gap_done, last_bit;
    logic accept, rise, fall, finish;

    assign div_done = (div_q == DW'(CLK_DIV - 1));
    assign gap_done = (gap_q == GW'(GAP_CYCLES - 1));
    assign last_bit = (bit_q == BW'(PIXEL_BITS - 1));

    assign tx_ready_o = (state_q == S_IDLE);
    assign busy_o     = ~tx_ready_o;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        div_d   = div_q + DW'(1);
        gap_d   = gap_q;
        accept  = 1'b0;
        rise    = 1'b0;
        fall    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (tx_valid_i) begin
                    accept  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP, S_LOW: begin
                if (div_done) begin
                    rise    = 1'b1;
                    div_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (div_done) begin
                    fall    = 1'b1;
                    div_d   = '0;
                    state_d = last_bit ? S_HOLD : S_LOW;
                end
            end
            S_HOLD: begin
                if (div_done) begin
                    finish  = 1'b1;
                    div_d   = '0;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                div_d = '0;
                if (gap_done) state_d = S_IDLE;
                else          gap_d   = gap_q + GW'(1);
            end
            default: begin
                div_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: asynchronous active-low reset; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
        end
    end

    // SDO is taken at the end of the high phase (on the falling edge), giving the
    // slave's synchronised shift path the whole high phase to settle.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            spi_cs_o   <= 1'b1;
            spi_sck_o  <= 1'b0;
            spi_sdi_o  <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            bit_q      <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            rx_valid_o <= finish;
            if (accept) begin
                tx_sh_q   <= tx_data_i;
                bit_q     <= '0;
                spi_cs_o  <= 1'b0;
                spi_sdi_o <= tx_data_i[PIXEL_BITS-1];
            end
            if (rise) spi_sck_o <= 1'b1;
            if (fall) begin
                spi_sck_o <= 1'b0;
                rx_sh_q   <= {rx_sh_q[PIXEL_BITS-2:0], spi_sdo_i};
                tx_sh_q   <= {tx_sh_q[PIXEL_BITS-2:0], 1'b0};
                spi_sdi_o <= tx_sh_q[PIXEL_BITS-2];
                bit_q     <= bit_q + BW'(1);
            end
            if (finish) begin
                spi_cs_o  <= 1'b1;
                spi_sdi_o <= 1'b0;
                rx_data_o <= rx_sh_q;
            end
        end
    end

endmodule

// File: tb/tb_spi_px_master.sv
// Randomised scoreboard bench for spi_px_master: a mode-0 slave model feeds SDO,
// expected words are queued at request time and checked when rx_valid_o strobes.
module tb_spi_px_master;

    localparam int P = 24;
    localparam int H = 4;
    localparam int G = 8;
    localparam int CS_LOW = (2 * P + 1) * H;   // 196
    localparam int READY_LOW = CS_LOW + G;      // 204

    logic         clk = 1'b0;
    logic         nreset_i;
    logic [P-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready, rx_valid, busy, spi_cs, spi_sck, spi_sdi, spi_sdo;
    logic [P-1:0] rx_data;

    logic [P-1:0] t6_data;
    logic         t6_valid, t6_ready, t6_rx_valid, t6_busy, t6_cs, t6_sck, t6_sdi;
    logic [P-1:0] t6_rx_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cs_falls = 0;

    logic [P-1:0] exp_rx[$];
    logic [P-1:0] exp_tx[$];

    bit           loopback = 1'b1;
    logic [P-1:0] slv_next = '0;
    logic [P-1:0] slv_word = '0;
    int           slv_idx = P - 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_px_master #(.PIXEL_BITS(P), .CLK_DIV(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .nreset_i(nreset_i),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
        .spi_cs_o(spi_cs), .spi_sck_o(spi_sck), .spi_sdi_o(spi_sdi), .spi_sdo_i(spi_sdo)
    );

    spi_px_master #(.PIXEL_BITS(P), .CLK_DIV(6), .GAP_CYCLES(1)) dut6 (
        .clk(clk), .nreset_i(nreset_i),
        .tx_data_i(t6_data), .tx_valid_i(t6_valid), .tx_ready_o(t6_ready),
        .rx_data_o(t6_rx_data), .rx_valid_o(t6_rx_valid), .busy_o(t6_busy),
        .spi_cs_o(t6_cs), .spi_sck_o(t6_sck), .spi_sdi_o(t6_sdi), .spi_sdo_i(t6_sdi)
    );

    // Mode-0 slave: first bit appears when CS falls, next bit after each SCK fall.
    always @(negedge spi_cs) begin
        slv_word = slv_next;
        slv_idx  = P - 1;
    end
    always @(negedge spi_sck) if (!spi_cs && slv_idx > 0) slv_idx--;
    assign spi_sdo = loopback ? spi_sdi : (spi_cs ? 1'b0 : slv_word[slv_idx]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: frame timing, SDI word, and scoreboard pop on each rx_valid_o strobe.
    bit           prev_cs = 1'b1, prev_sck = 1'b0, prev_ready = 1'b1, rst_seen = 1'b0;
    int           cs_fall_cyc = 0, ready_fall_cyc = 0, rises = 0;
    logic [P-1:0] sdi_word = '0;

    always @(negedge clk) begin
        if (!nreset_i) begin
            rst_seen   = 1'b1;
            prev_cs    = 1'b1;
            prev_sck   = 1'b0;
            prev_ready = 1'b1;
        end else begin
            if (prev_cs && !spi_cs) begin
                cs_fall_cyc = cyc;
                rises       = 0;
                sdi_word    = '0;
                cs_falls++;
            end
            if (!prev_sck && spi_sck) begin
                rises++;
                sdi_word = {sdi_word[P-2:0], spi_sdi};
                if (rises == 1) check("first_sck_rise", cyc - cs_fall_cyc, H);
            end
            if (rx_valid) begin
                check("rx_valid_cycle", cyc - cs_fall_cyc, CS_LOW);
                check("cs_high_at_rx", spi_cs, 1);
                check("busy_at_rx", busy, 1);
                check("sck_rises", rises, P);
                if (exp_rx.size() == 0) begin
                    check("unexpected_rx", 1, 0);
                end else begin
                    check("rx_data", rx_data, exp_rx.pop_front());
                    check("sdi_word", sdi_word, exp_tx.pop_front());
                end
            end
            if (prev_ready && !tx_ready) begin
                ready_fall_cyc = cyc;
                rst_seen       = 1'b0;
            end
            if (!prev_ready && tx_ready && !rst_seen)
                check("ready_low_cycles", cyc - ready_fall_cyc, READY_LOW);
            prev_cs    = spi_cs;
            prev_sck   = spi_sck;
            prev_ready = tx_ready;
        end
    end

    task automatic send(input logic [P-1:0] w, input bit hold, input bit expect_rx);
        int n = 0;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        if (expect_rx) begin
            exp_rx.push_back(loopback ? w : slv_next);
            exp_tx.push_back(w);
        end
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("send_timeout", 1, 0);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(tx_ready && exp_rx.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, n, n_rx, n_rdy;
        logic [P-1:0] w1, w2;
        nreset_i = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        t6_data  = '0;
        t6_valid = 1'b0;
        #12;
        check("rst_cs", spi_cs, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_sdi", spi_sdi, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        @(negedge clk);
        nreset_i = 1'b1;
        repeat (2) @(negedge clk);

        // CLK_DIV=6, GAP_CYCLES=1 loopback: rx at 49*6=294, ready at 295.
        t6_data  = 24'hA5C3F0;
        t6_valid = 1'b1;
        @(negedge clk);
        t6_valid = 1'b0;
        n = 0; n_rx = -1; n_rdy = -1;
        while (n < 400 && n_rdy < 0) begin
            @(negedge clk);
            n++;
            if (t6_rx_valid) begin
                n_rx = n;
                check("p6_rx_data", t6_rx_data, 24'hA5C3F0);
            end
            if (t6_ready) n_rdy = n;
        end
        check("p6_rx_cycle", n_rx, 294);
        check("p6_ready_cycle", n_rdy, 295);

        // Loopback.
        loopback = 1'b1;
        send(24'hA5C3F0, 1'b0, 1'b1);
        wait_idle();

        // Bit timing against the slave model.
        loopback = 1'b0;
        slv_next = 24'h123456;
        send(24'h800001, 1'b0, 1'b1);
        wait_idle();

        // Back-to-back with tx_valid held: next frame starts on the first IDLE cycle.
        loopback = 1'b1;
        send(24'h000001, 1'b1, 1'b1);
        send(24'hFFFFFF, 1'b0, 1'b1);
        wait_idle();

        // Request while busy is ignored.
        f0 = cs_falls;
        send(24'h3C3C3C, 1'b0, 1'b1);
        repeat (48) @(negedge clk);
        tx_data  = 24'h111111;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();
        repeat (300) @(negedge clk);
        check("no_extra_frame", cs_falls - f0, 1);

        // Reset mid-frame.
        send(24'h654321, 1'b0, 1'b0);
        repeat (98) @(negedge clk);
        #2 nreset_i = 1'b0;
        #1;
        check("mid_rst_cs", spi_cs, 1);
        check("mid_rst_sck", spi_sck, 0);
        check("mid_rst_ready", tx_ready, 1);
        check("mid_rst_rx_valid", rx_valid, 0);
        repeat (3) @(negedge clk);
        nreset_i = 1'b1;
        repeat (2) @(negedge clk);
        send(24'h00FF00, 1'b0, 1'b1);
        wait_idle();

        // Randomised frames, sometimes back-to-back.
        for (int i = 0; i < 25; i++) begin
            loopback = 1'($urandom_range(0, 1));
            slv_next = P'($urandom);
            w1 = P'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                send(w1, 1'b1, 1'b1);
                slv_next = P'($urandom);
                w2 = P'($urandom);
                send(w2, 1'b0, 1'b1);
            end else begin
                send(w1, 1'b0, 1'b1);
            end
            wait_idle();
        end

        check("scoreboard_empty", exp_rx.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
